dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: N_REQ, 2, number of requesters (fixed at 2 in this release).
REQ-002 Parameter: ADDR_W, 16, byte-address width of data memory.
REQ-003 Parameter: DATA_W, 32, word width.
REQ-004 Port: i_clk  input  1  sole clock; all logic on posedge.
REQ-005 Port: i_rst  input  1  synchronous, active-high reset.
REQ-006 Port: i_req_valid  input  2  per-requester request valid.
REQ-007 Port: o_req_ready  output  2  one-hot grant pulse; request accepted when valid&ready.
REQ-008 Port: i_req_A  input  2x16  per-requester byte address.
REQ-009 Port: i_req_WD  input  2x32  per-requester write data.
REQ-010 Port: i_req_WE  input  2  per-requester write enable (0 = read).
REQ-011 Port: o_rsp_valid  output  2  one-hot, one-cycle completion pulse to the granted requester.
REQ-012 Port: o_rsp_RD  output  32  read data, valid with o_rsp_valid; 0 for writes and errors.
REQ-013 Port: o_rsp_err  output  1  address-range error flag, valid with o_rsp_valid.
REQ-014 Port: o_mem_A / o_mem_WD / o_mem_WE  output  16/32/1  data-memory port.
REQ-015 Port: i_mem_RD  input  32  data-memory combinational read data.
REQ-016 Port: o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, RESP; registered state.
REQ-018 IDLE: if any i_req_valid, arbiter SHALL assert o_req_ready for exactly one winner in the same cycle, latch its A/WD/WE/index, and go to ACCESS; otherwise stay in IDLE.
REQ-019 ACCESS (exactly 1 cycle): o_mem_A = latched A, o_mem_WD = latched WD, o_mem_WE = latched WE & ~err & ~i_rst; i_mem_RD captured at end of cycle; go to RESP.
REQ-020 RESP (exactly 1 cycle): o_rsp_valid[idx]=1, o_rsp_RD/o_rsp_err driven from registers; go to IDLE.
REQ-021 Latency: grant at cycle N, memory access N+1, response N+2; throughput one transaction per 3 cycles.
REQ-022 Outside ACCESS: o_mem_WE=0, o_mem_A and o_mem_WD hold their last values.
REQ-023 o_req_ready SHALL be 0 in ACCESS and RESP, regardless of i_req_valid.
REQ-024 Address error: latched A > 0xFFFC (word would wrap past top of memory) -> no write issued, o_rsp_err=1, o_rsp_RD=0.
REQ-025 Unaligned addresses <= 0xFFFC are legal and passed through unchanged.
REQ-026 A requester must hold valid and payload until ready; a requester deasserting valid without ready gets no grant.

Reset
REQ-027 On i_rst: state=IDLE; o_req_ready=0, o_rsp_valid=0, o_rsp_RD=0, o_rsp_err=0, o_mem_A=0, o_mem_WD=0, o_mem_WE=0, o_busy=0; RR pointer = 1.
REQ-028 Reset during ACCESS SHALL suppress the write in that cycle (o_mem_WE gated by i_rst); the in-flight transaction is dropped with no response.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round-robin; the requester not granted last wins a tie; pointer updates on every grant.
REQ-030 Macro DMEM_ARB_RR_EN undefined: fixed priority; requester 0 always wins a tie; no pointer register.

Structure
REQ-031 Package mips_mem_pkg SHALL hold the FSM state enum, ADDR_W, DATA_W, N_REQ, and the max legal address constant 0xFFFC.
REQ-032 Winner selection SHALL be a sub-module dmem_arb_pick (valid vector + pointer in, one-hot grant out, combinational).

Verification
REQ-033 Req0 write A=0x0010 WD=0xDEADBEEF, then read -> o_mem_WE high for exactly one cycle at N+1; read rsp at N+2 returns 0xDEADBEEF, err=0.
REQ-034 Both valid every cycle for 4 transactions -> RR build: grants 0,1,0,1; fixed build: grants 0,0,0,0.
REQ-035 Req1 write A=0xFFFD -> no o_mem_WE pulse, o_rsp_valid[1]=1, o_rsp_err=1, o_rsp_RD=0.
REQ-036 Req0 write A=0x0020 with i_rst asserted in its ACCESS cycle -> no write pulse, no response, all outputs 0 next cycle, subsequent read of 0x0020 returns prior contents.
REQ-037 Req0 read A=0xFFFC -> err=0, data = bytes 0xFFFC..0xFFFF little-endian.
REQ-038 Valid held during ACCESS/RESP -> o_req_ready stays 0 until IDLE, then pulses once.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared constants and FSM state type for the data-memory arbiter.
package mips_mem_pkg;

    parameter int unsigned N_REQ  = 2;
    parameter int unsigned ADDR_W = 16;
    parameter int unsigned DATA_W = 32;

    // Highest byte address whose 4-byte word does not wrap past the top of memory.
    parameter logic [ADDR_W-1:0] MAX_ADDR = 16'hFFFC;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and data-memory signal bundle for dmem_arbiter.
interface dmem_arbiter_if;
    import mips_mem_pkg::*;

    logic [N_REQ-1:0]             i_req_valid;
    logic [N_REQ-1:0]             o_req_ready;
    logic [N_REQ-1:0][ADDR_W-1:0] i_req_A;
    logic [N_REQ-1:0][DATA_W-1:0] i_req_WD;
    logic [N_REQ-1:0]             i_req_WE;
    logic [N_REQ-1:0]             o_rsp_valid;
    logic [DATA_W-1:0]            o_rsp_RD;
    logic                         o_rsp_err;
    logic [ADDR_W-1:0]            o_mem_A;
    logic [DATA_W-1:0]            o_mem_WD;
    logic                         o_mem_WE;
    logic [DATA_W-1:0]            i_mem_RD;
    logic                         o_busy;

    modport slave (
        input  i_req_valid, i_req_A, i_req_WD, i_req_WE, i_mem_RD,
        output o_req_ready, o_rsp_valid, o_rsp_RD, o_rsp_err,
        output o_mem_A, o_mem_WD, o_mem_WE, o_busy
    );

    modport master (
        output i_req_valid, i_req_A, i_req_WD, i_req_WE, i_mem_RD,
        input  o_req_ready, o_rsp_valid, o_rsp_RD, o_rsp_err,
        input  o_mem_A, o_mem_WD, o_mem_WE, o_busy
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select: the requester after ptr_i (the last one granted) wins a tie.
module dmem_arb_pick
    import mips_mem_pkg::*;
(
    input  logic [N_REQ-1:0] valid_i,
    input  logic             ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic first;

    assign first = ~ptr_i;

    always_comb begin
        grant_o = '0;
        if (valid_i[first]) begin
            grant_o[first] = 1'b1;
        end else if (valid_i[ptr_i]) begin
            grant_o[ptr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one transaction per three cycles (IDLE/ACCESS/RESP).
// Define DMEM_ARB_RR_EN for round-robin; otherwise requester 0 has fixed priority.
module dmem_arbiter
    import mips_mem_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    dmem_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  grant;
    logic              pick_ptr;
    logic              accept;
    logic              addr_err;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] rd_q;
    logic              we_q;
    logic              err_q;
    logic              idx_q;

    dmem_arb_pick u_pick (
        .valid_i (bus.i_req_valid),
        .ptr_i   (pick_ptr),
        .grant_o (grant)
    );

`ifdef DMEM_ARB_RR_EN
    logic ptr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= 1'b1;
        end else if (accept) begin
            ptr_q <= grant[1];
        end
    end

    assign pick_ptr = ptr_q;
`else
    // Pretending requester 1 was granted last hands every tie to requester 0.
    assign pick_ptr = 1'b1;
`endif

    assign accept   = (state_q == StIdle) && !i_rst && (|bus.i_req_valid);
    assign addr_err = a_q > MAX_ADDR;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            idx_q   <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q   <= bus.i_req_A[grant[1]];
                wd_q  <= bus.i_req_WD[grant[1]];
                we_q  <= bus.i_req_WE[grant[1]];
                idx_q <= grant[1];
            end
            if (state_q == StAccess) begin
                err_q <= addr_err;
                rd_q  <= (we_q || addr_err) ? '0 : bus.i_mem_RD;
            end
        end
    end

    always_comb begin
        bus.o_req_ready = '0;
        bus.o_rsp_valid = '0;
        bus.o_rsp_RD    = '0;
        bus.o_rsp_err   = 1'b0;
        if (accept) begin
            bus.o_req_ready = grant;
        end
        if (state_q == StResp) begin
            bus.o_rsp_valid[idx_q] = 1'b1;
            bus.o_rsp_RD           = rd_q;
            bus.o_rsp_err          = err_q;
        end
    end

    // a_q/wd_q only change on a grant, so the memory port holds its last values between accesses.
    assign bus.o_mem_A  = a_q;
    assign bus.o_mem_WD = wd_q;
    assign bus.o_mem_WE = (state_q == StAccess) && we_q && !addr_err && !i_rst;
    assign bus.o_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard and a byte-array memory model.
module tb_dmem_arbiter;
    import mips_mem_pkg::*;

    typedef struct packed {
        logic        idx;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic init_req;
    int   vectors = 0;
    int   miscompares = 0;
    int   we_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [7:0]  mem [0:65535];
    logic [15:0] ma1, ma2, ma3;

    assign ma1 = bus.o_mem_A + 16'd1;
    assign ma2 = bus.o_mem_A + 16'd2;
    assign ma3 = bus.o_mem_A + 16'd3;
    assign bus.i_mem_RD = {mem[ma3], mem[ma2], mem[ma1], mem[bus.o_mem_A]};

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'(i + 3);
            mem[16'hFFFC] = 8'h11;
            mem[16'hFFFD] = 8'h22;
            mem[16'hFFFE] = 8'h33;
            mem[16'hFFFF] = 8'h44;
        end
        if (bus.o_mem_WE) begin
            mem[bus.o_mem_A] = bus.o_mem_WD[7:0];
            mem[ma1]         = bus.o_mem_WD[15:8];
            mem[ma2]         = bus.o_mem_WD[23:16];
            mem[ma3]         = bus.o_mem_WD[31:24];
        end
    end

    function automatic logic [1:0] onehot(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.o_mem_WE === 1'b1) we_cnt++;
        if (bus.o_rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.o_rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(onehot(e.idx)));
                chk("rsp_RD", bus.o_rsp_RD, e.rd);
                chk("rsp_err", 32'(bus.o_rsp_err), 32'(e.err));
            end
        end
    end

    task automatic wait_grant(input logic [1:0] exp);
        int n = 0;
        @(negedge clk);
        while (bus.o_req_ready === 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("grant", 32'(bus.o_req_ready), 32'(exp));
    endtask

    task automatic wait_rsp();
        int n = 0;
        #1;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rsp_drain", sb.size(), 32'd0);
    endtask

    task automatic do_req(input int r, input logic [15:0] a, input logic [31:0] wd,
                          input logic we, input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk);
        #1;
        bus.i_req_valid[r] = 1'b1;
        bus.i_req_A[r]     = a;
        bus.i_req_WD[r]    = wd;
        bus.i_req_WE[r]    = we;
        sb.push_back('{idx: r[0], rd: exp_rd, err: exp_err});
        wait_grant(onehot(r[0]));
        @(posedge clk);
        #1;
        bus.i_req_valid[r] = 1'b0;
        @(negedge clk);
        chk("access_mem_WE", 32'(bus.o_mem_WE), 32'(we & ~exp_err));
        chk("access_mem_A", 32'(bus.o_mem_A), 32'(a));
        chk("access_busy", 32'(bus.o_busy), 32'd1);
        chk("access_ready", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        chk("resp_mem_WE", 32'(bus.o_mem_WE), 32'd0);
        wait_rsp();
    endtask

    initial begin
        int base;
        logic exp_idx [4];
`ifdef DMEM_ARB_RR_EN
        exp_idx = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_idx = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        rst             = 1'b1;
        init_req        = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_A     = '0;
        bus.i_req_WD    = '0;
        bus.i_req_WE    = '0;
        repeat (3) @(posedge clk);
        #1;
        init_req = 1'b0;
        rst      = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rst_rsp_RD", bus.o_rsp_RD, 32'd0);
        chk("rst_rsp_err", 32'(bus.o_rsp_err), 32'd0);
        chk("rst_mem_A", 32'(bus.o_mem_A), 32'd0);
        chk("rst_mem_WD", bus.o_mem_WD, 32'd0);
        chk("rst_mem_WE", 32'(bus.o_mem_WE), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);

        // Write then read back
        base = we_cnt;
        do_req(0, 16'h0010, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        chk("write_pulses", we_cnt - base, 32'd1);
        do_req(0, 16'h0010, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);

        // Out-of-range write is suppressed and flagged
        base = we_cnt;
        do_req(1, 16'hFFFD, 32'h12345678, 1'b1, 32'h0, 1'b1);
        chk("err_no_write", we_cnt - base, 32'd0);

        // Both requesters contend for four transactions
        @(posedge clk);
        #1;
        bus.i_req_valid = 2'b11;
        bus.i_req_A[0]  = 16'h0010;
        bus.i_req_WE[0] = 1'b0;
        bus.i_req_A[1]  = 16'hFFFC;
        bus.i_req_WE[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(onehot(exp_idx[k]));
            sb.push_back('{idx: exp_idx[k], rd: exp_idx[k] ? 32'h44332211 : 32'hDEADBEEF,
                           err: 1'b0});
        end
        @(posedge clk);
        #1;
        bus.i_req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        wait_rsp();

        // Top legal address
        do_req(0, 16'hFFFC, 32'h0, 1'b0, 32'h44332211, 1'b0);

        // Valid held across ACCESS/RESP
        @(posedge clk);
        #1;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_A[0]     = 16'h0010;
        bus.i_req_WE[0]    = 1'b0;
        sb.push_back('{idx: 1'b0, rd: 32'hDEADBEEF, err: 1'b0});
        sb.push_back('{idx: 1'b0, rd: 32'hDEADBEEF, err: 1'b0});
        wait_grant(2'b01);
        @(negedge clk);
        chk("hold_ready_access", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        chk("hold_ready_resp", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        chk("hold_ready_idle", 32'(bus.o_req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_req_valid[0] = 1'b0;
        @(negedge clk);
        chk("hold_ready_once", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        wait_rsp();

        // Reset during ACCESS drops the write
        base = we_cnt;
        @(posedge clk);
        #1;
        bus.i_req_valid[0] = 1'b1;
        bus.i_req_A[0]     = 16'h0020;
        bus.i_req_WD[0]    = 32'hCAFEF00D;
        bus.i_req_WE[0]    = 1'b1;
        wait_grant(2'b01);
        @(posedge clk);
        #1;
        bus.i_req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstacc_mem_WE", 32'(bus.o_mem_WE), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstacc_ready", 32'(bus.o_req_ready), 32'd0);
        chk("rstacc_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        chk("rstacc_rsp_RD", bus.o_rsp_RD, 32'd0);
        chk("rstacc_rsp_err", 32'(bus.o_rsp_err), 32'd0);
        chk("rstacc_mem_A", 32'(bus.o_mem_A), 32'd0);
        chk("rstacc_mem_WD", bus.o_mem_WD, 32'd0);
        chk("rstacc_mem_WE2", 32'(bus.o_mem_WE), 32'd0);
        chk("rstacc_busy", 32'(bus.o_busy), 32'd0);
        chk("rstacc_no_write", we_cnt - base, 32'd0);
        do_req(0, 16'h0020, 32'h0, 1'b0, 32'h26252423, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
